// File: rtl/shift_pkg.sv
// shift_pkg: opcodes, select encoding, FSM states and the shift_reg next-state function
package shift_pkg;
    localparam int SR_W = 4;
    localparam logic [1:0] OP_ROTL = 2'b00;
    localparam logic [1:0] OP_ROTR = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;
    typedef enum logic [1:0] {
        SEL_ROTL = 2'b00,
        SEL_ROTR = 2'b01,
        SEL_HOLD = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_FIN
    } state_e;
    function automatic logic [SR_W-1:0] sr_next(sel_e sel, logic [SR_W-1:0] q, logic [SR_W-1:0] d);
        return sel == SEL_LOAD ? d :
               sel == SEL_ROTL ? {q[SR_W-2:0], q[SR_W-1]} :
               sel == SEL_ROTR ? {q[0], q[SR_W-1:1]} : q;
    endfunction
endpackage

// File: rtl/shift_shadow_model.sv
// shift_shadow_model: registered copy of shift_reg behaviour, tracking what its Q should hold
module shift_shadow_model
    import shift_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  sel_e            sel_i,
    input  logic [SR_W-1:0] d_i,
    output logic [SR_W-1:0] q_o
);
    logic [SR_W-1:0] q_q;
    logic [SR_W-1:0] q_d;
    assign q_d = sr_next(sel_i, q_q, d_i);
    assign q_o = q_q;
    // Apply the same select the real register sees on every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: expands load/rotate/hold commands into shift_reg selects and checks the result
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic [CNT_W-1:0] CMD_CNT,
    output logic             SEL_S1,
    output logic             SEL_S0,
    output logic [WIDTH-1:0] D_OUT,
    input  logic [WIDTH-1:0] Q_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] EXP_Q,
    output logic             SYNCED,
    output logic             MISMATCH
);
    state_e             state_q, state_d;
    sel_e               sel_q, sel_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               synced_q, synced_d;
    logic               mm_q, mm_d;

    assign CMD_READY = state_q == S_IDLE;
    assign BUSY      = state_q != S_IDLE;
    assign DONE      = state_q == S_FIN;
    assign SEL_S1    = sel_q[1];
    assign SEL_S0    = sel_q[0];
    assign D_OUT     = dout_q;
    assign SYNCED    = synced_q;
    assign MISMATCH  = mm_q;

    // Next state and the select for the next cycle; selects are decided one edge early so they leave registered
    always_comb begin
        state_d  = state_q;
        sel_d    = SEL_HOLD;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        synced_d = synced_q;
        mm_d     = mm_q;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_OP == OP_LOAD) begin
                        state_d = S_LOAD;
                        sel_d   = SEL_LOAD;
                        dout_d  = CMD_DATA;
                    end else if (CMD_OP == OP_HOLD) begin
                        state_d = S_HOLD;
                    end else if (CMD_CNT != '0) begin
                        state_d = S_SHIFT;
                        sel_d   = sel_e'(CMD_OP);
                        cnt_d   = CMD_CNT;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                state_d  = S_FIN;
                synced_d = 1'b1;
            end
            S_SHIFT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CNT_W'(1) ? S_FIN : S_SHIFT;
                sel_d   = cnt_q == CNT_W'(1) ? SEL_HOLD : sel_q;
            end
            S_HOLD: state_d = S_FIN;
            S_FIN: begin
                state_d = S_IDLE;
                mm_d    = mm_q | (synced_q && Q_IN != EXP_Q);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, output registers and sticky status flags
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            sel_q    <= SEL_HOLD;
            dout_q   <= '0;
            cnt_q    <= '0;
            synced_q <= 1'b0;
            mm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            synced_q <= synced_d;
            mm_q     <= mm_d;
        end
    end

    shift_shadow_model u_shadow (
        .clk   (CLK),
        .rst_n (RSTn),
        .sel_i (sel_q),
        .d_i   (dout_q),
        .q_o   (EXP_Q)
    );
endmodule
